// File: rtl/mem_arbiter_if.sv
// Channel and RAM-side bus of the multi-channel byte-serial memory arbiter.
// The arbiter connects through the slave modport; requesters/RAM models use master.
interface mem_arbiter_if #(
    parameter int NCH = 2
);
    logic              rdy;
    logic [NCH-1:0]    req;
    logic [NCH-1:0]    we;
    logic [NCH*32-1:0] addr;
    logic [NCH*2-1:0]  len;
    logic [NCH*32-1:0] wdata;
    logic [NCH-1:0]    ack;
    logic [NCH-1:0]    done;
    logic [31:0]       rdata;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [31:0]       mem_a;
    logic              mem_wr;

    modport slave (
        input  rdy, req, we, addr, len, wdata, mem_din,
        output ack, done, rdata, mem_dout, mem_a, mem_wr
    );

    modport master (
        output rdy, req, we, addr, len, wdata, mem_din,
        input  ack, done, rdata, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates NCH channels onto one byte-wide RAM port; each transfer moves 1..4
// bytes serially, reads assemble a little-endian word presented with done.
module mem_arbiter #(
    parameter int NCH       = 2,
    parameter int PRIO_MODE = 0
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, TAIL, DONE} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] rr_ptr, gnt;
    logic [IW-1:0] pick, pick_lo, pick_hi;
    logic          hi_found, any_req, start;
    logic [31:0]   base;
    logic [1:0]    len_q, cnt;
    logic          we_q;
    logic [31:0]   wdata_q, rdata_q;

    assign any_req = |bus.req;
    assign start   = rst && bus.rdy && (state == IDLE) && any_req;

    // Round-robin prefers the lowest requester above the last grant, else wraps
    // to the lowest requester overall; fixed priority always takes the lowest.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pick_lo  = '0;
        pick_hi  = '0;
        hi_found = 1'b0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (bus.req[c]) begin
                pick_lo = IW'(c);
                if (c > int'(rr_ptr)) begin
                    pick_hi  = IW'(c);
                    hi_found = 1'b1;
                end
            end
        end
        pick = (PRIO_MODE == 0 && hi_found) ? pick_hi : pick_lo;
    end

    always_comb begin
        state_nx = state;
        if (bus.rdy) begin
            case (state)
                IDLE:    if (any_req) state_nx = BUSY;
                BUSY:    if (cnt == len_q) state_nx = we_q ? DONE : TAIL;
                TAIL:    state_nx = DONE;
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr  <= IW'(NCH - 1);
            gnt     <= '0;
            base    <= '0;
            len_q   <= '0;
            cnt     <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else if (bus.rdy) begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt     <= pick;
                        rr_ptr  <= pick;
                        base    <= bus.addr[{pick, 5'b0} +: 32];
                        len_q   <= bus.len[{pick, 1'b0} +: 2];
                        we_q    <= bus.we[pick];
                        wdata_q <= bus.wdata[{pick, 5'b0} +: 32];
                        cnt     <= '0;
                        rdata_q <= '0;
                    end
                end
                BUSY: begin
                    // RAM data lags its address by one cycle, so byte i-1 lands now.
                    if (!we_q && cnt != 2'd0)
                        rdata_q[{cnt - 2'd1, 3'b0} +: 8] <= bus.mem_din;
                    if (cnt != len_q)
                        cnt <= cnt + 2'd1;
                end
                TAIL: rdata_q[{len_q, 3'b0} +: 8] <= bus.mem_din;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.ack      = '0;
        bus.done     = '0;
        bus.mem_a    = '0;
        bus.mem_dout = '0;
        bus.mem_wr   = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            bus.ack[c]  = start && (pick == IW'(c));
            bus.done[c] = bus.rdy && (state == DONE) && (gnt == IW'(c));
        end
        if (state == BUSY) begin
            bus.mem_a    = base + {30'b0, cnt};
            bus.mem_wr   = we_q && bus.rdy;
            bus.mem_dout = we_q ? wdata_q[{cnt, 3'b0} +: 8] : 8'h00;
        end
    end

    assign bus.rdata = rdata_q;
endmodule
